// File: rtl/vga_pkg.sv
// vga_pkg: raster timing constants for 800x600@60 (40 MHz pixel clock) and the shared
// counter type used by the timing generator and every drawing stage downstream.
package vga_pkg;

  localparam int unsigned VGA_CNT_W = 11;

  typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

  // Horizontal: 800 visible, 40 front porch, 128 sync, 88 back porch.
  localparam vga_cnt_t HOR_TOTAL_TIME  = 11'd1056;
  localparam vga_cnt_t HOR_BLANK_START = 11'd800;
  localparam vga_cnt_t HOR_SYNC_START  = 11'd840;
  localparam vga_cnt_t HOR_SYNC_TIME   = 11'd128;

  // Vertical: 600 visible, 1 front porch, 4 sync, 23 back porch (in lines).
  localparam vga_cnt_t VER_TOTAL_TIME  = 11'd628;
  localparam vga_cnt_t VER_BLANK_START = 11'd600;
  localparam vga_cnt_t VER_SYNC_START  = 11'd601;
  localparam vga_cnt_t VER_SYNC_TIME   = 11'd4;

  // True when lo <= x < lo + len. The subtraction wraps for x < lo, giving a value
  // that is never below len for any window that fits in the counter range.
  function automatic logic in_window(input vga_cnt_t x, input vga_cnt_t lo,
                                     input vga_cnt_t len);
    vga_cnt_t d;
    d = x - lo;
    return d < len;
  endfunction

endpackage

// File: rtl/vga_axis_timing.sv
// vga_axis_timing: one raster axis. A wrapping position counter with a carry-out on
// its last position, plus blank and sync flags decoded from the next count and
// registered alongside it so flags always describe the count being shown.
//   clk    in   pixel clock
//   rst_n  in   synchronous reset, active-low
//   en     in   advance by one position this cycle
//   count  out  current position, 0..Total-1
//   carry  out  combinational: en is high and count is at Total-1 (wraps this edge)
//   blnk   out  count >= BlankStart
//   sync   out  SyncStart <= count < SyncStart+SyncTime
module vga_axis_timing
  import vga_pkg::*;
#(
  parameter vga_cnt_t Total      = HOR_TOTAL_TIME,
  parameter vga_cnt_t BlankStart = HOR_BLANK_START,
  parameter vga_cnt_t SyncStart  = HOR_SYNC_START,
  parameter vga_cnt_t SyncTime   = HOR_SYNC_TIME
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  output vga_cnt_t count,
  output logic     carry,
  output logic     blnk,
  output logic     sync
);

  vga_cnt_t count_q, count_d;
  logic     blnk_q, sync_q;
  logic     last;

  assign last  = (count_q == Total - 1'b1);
  assign carry = en & last;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  // Flags are recomputed from count_d every cycle; with en low count_d equals count_q,
  // so they hold along with the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      blnk_q  <= (count_d >= BlankStart);
      sync_q  <= in_window(count_d, SyncStart, SyncTime);
    end
  end

  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator. All outputs are registered and
// aligned to the same pixel.
//   clk        in   pixel clock (40 MHz)
//   rst_n      in   synchronous reset, active-low; overrides en
//   en         in   pixel-advance enable; everything holds while low and sof reads 0
//   hcount     out  horizontal position
//   vcount     out  vertical position
//   hsync      out  active-high horizontal sync
//   vsync      out  active-high vertical sync
//   hblnk      out  horizontal blanking
//   vblnk      out  vertical blanking
//   sof        out  one-cycle pulse while the first (0,0) after a frame wrap is shown
//   frame_cnt  out  completed-frame count, wraps modulo 2^FRAME_CNT_W
// Geometry parameters default to the 800x600@60 constants; overriding them gives a
// smaller raster with identical behaviour.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W = 16,
  parameter vga_cnt_t HorTotal      = HOR_TOTAL_TIME,
  parameter vga_cnt_t HorBlankStart = HOR_BLANK_START,
  parameter vga_cnt_t HorSyncStart  = HOR_SYNC_START,
  parameter vga_cnt_t HorSyncTime   = HOR_SYNC_TIME,
  parameter vga_cnt_t VerTotal      = VER_TOTAL_TIME,
  parameter vga_cnt_t VerBlankStart = VER_BLANK_START,
  parameter vga_cnt_t VerSyncStart  = VER_SYNC_START,
  parameter vga_cnt_t VerSyncTime   = VER_SYNC_TIME
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output vga_cnt_t               hcount,
  output vga_cnt_t               vcount,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hblnk,
  output logic                   vblnk,
  output logic                   sof,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  logic h_carry, v_carry;

  vga_axis_timing #(
    .Total      (HorTotal),
    .BlankStart (HorBlankStart),
    .SyncStart  (HorSyncStart),
    .SyncTime   (HorSyncTime)
  ) u_hor (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .count (hcount),
    .carry (h_carry),
    .blnk  (hblnk),
    .sync  (hsync)
  );

  // h_carry already includes en, so the vertical axis only steps on enabled line ends.
  vga_axis_timing #(
    .Total      (VerTotal),
    .BlankStart (VerBlankStart),
    .SyncStart  (VerSyncStart),
    .SyncTime   (VerSyncTime)
  ) u_ver (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_carry),
    .count (vcount),
    .carry (v_carry),
    .blnk  (vblnk),
    .sync  (vsync)
  );

  logic                   sof_q, sof_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // v_carry marks the edge that wraps to (0,0); registering it lines sof up with the
  // counters showing (0,0). Reset never raises v_carry, so no pulse follows reset.
  always_comb begin
    sof_d       = v_carry;
    frame_cnt_d = frame_cnt_q;
    if (v_carry) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sof       = sof_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for reset, line sweep, enable gating and
// mid-line reset, and a small-raster instance (16x10, 2-bit frame counter) for frame
// wrap, sof spacing, vertical flags, enable gating at the frame end and mid-frame reset.
// The driver pushes expected outputs into per-instance queues; a monitor samples on
// the falling edge and compares whenever the head entry is due.
module tb_vga_timing;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, rst_n_s, en_s;

  vga_cnt_t    hcount, vcount, hcount_s, vcount_s;
  logic        hsync, vsync, hblnk, vblnk, sof;
  logic        hsync_s, vsync_s, hblnk_s, vblnk_s, sof_s;
  logic [15:0] frame_cnt;
  logic [1:0]  frame_cnt_s;

  vga_timing dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync     (hsync),
    .vsync     (vsync),
    .hblnk     (hblnk),
    .vblnk     (vblnk),
    .sof       (sof),
    .frame_cnt (frame_cnt)
  );

  vga_timing #(
    .FRAME_CNT_W   (2),
    .HorTotal      (11'd16),
    .HorBlankStart (11'd10),
    .HorSyncStart  (11'd12),
    .HorSyncTime   (11'd2),
    .VerTotal      (11'd10),
    .VerBlankStart (11'd6),
    .VerSyncStart  (11'd7),
    .VerSyncTime   (11'd2)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_n_s),
    .en        (en_s),
    .hcount    (hcount_s),
    .vcount    (vcount_s),
    .hsync     (hsync_s),
    .vsync     (vsync_s),
    .hblnk     (hblnk_s),
    .vblnk     (vblnk_s),
    .sof       (sof_s),
    .frame_cnt (frame_cnt_s)
  );

  typedef struct {
    int          at;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        sf;
    logic [15:0] fc;
    logic [79:0] name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   eh[2];
  int   ev[2];
  int   efc[2];
  logic esof[2];

  // Expected outputs for instance g at its current expected position.
  function automatic exp_t mk(input int g, input logic [79:0] nm);
    exp_t e;
    int   h, v;
    h = eh[g];
    v = ev[g];
    e.at   = cyc;
    e.h    = h[10:0];
    e.v    = v[10:0];
    e.sf   = esof[g];
    e.fc   = efc[g][15:0];
    e.name = nm;
    if (g == 0) begin
      e.hb = (h >= 800);
      e.vb = (v >= 600);
      e.hs = (h >= 840) && (h < 968);
      e.vs = (v >= 601) && (v < 605);
    end else begin
      e.hb = (h >= 10);
      e.vb = (v >= 6);
      e.hs = (h >= 12) && (h < 14);
      e.vs = (v >= 7) && (v < 9);
    end
    return e;
  endfunction

  task automatic push(input int g, input logic [79:0] nm);
    exp_t e;
    e = mk(g, nm);
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled pixel step of the expected raster position.
  task automatic adv(input int g);
    int ht, vt, fmask;
    ht    = (g == 0) ? 1056 : 16;
    vt    = (g == 0) ? 628 : 10;
    fmask = (g == 0) ? 32'hffff : 32'h3;
    esof[g] = 1'b0;
    if (eh[g] == ht - 1) begin
      eh[g] = 0;
      if (ev[g] == vt - 1) begin
        ev[g]   = 0;
        efc[g]  = (efc[g] + 1) & fmask;
        esof[g] = 1'b1;
      end else begin
        ev[g] = ev[g] + 1;
      end
    end else begin
      eh[g] = eh[g] + 1;
    end
  endtask

  task automatic step(input int g, input int n, input logic [79:0] nm);
    repeat (n) begin
      tick();
      adv(g);
      push(g, nm);
    end
  endtask

  task automatic hold(input int g, input int n, input logic [79:0] nm);
    repeat (n) begin
      tick();
      esof[g] = 1'b0;
      push(g, nm);
    end
  endtask

  // Leaves reset asserted; the caller releases it.
  task automatic do_reset(input int g, input int n, input logic [79:0] nm);
    if (g == 0) rst_n = 1'b0;
    else rst_n_s = 1'b0;
    repeat (n) begin
      tick();
      eh[g]   = 0;
      ev[g]   = 0;
      efc[g]  = 0;
      esof[g] = 1'b0;
      push(g, nm);
    end
  endtask

  task automatic check(input int g);
    exp_t e, a;
    int   qs;
    qs = (g == 0) ? q0.size() : q1.size();
    while (qs > 0) begin
      e = (g == 0) ? q0[0] : q1[0];
      if (e.at > cyc) break;
      if (g == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      qs = qs - 1;
      n_checks++;
      if (g == 0) begin
        a.h = hcount;   a.v = vcount;   a.hs = hsync;   a.vs = vsync;
        a.hb = hblnk;   a.vb = vblnk;   a.sf = sof;     a.fc = frame_cnt;
      end else begin
        a.h = hcount_s; a.v = vcount_s; a.hs = hsync_s; a.vs = vsync_s;
        a.hb = hblnk_s; a.vb = vblnk_s; a.sf = sof_s;   a.fc = {14'd0, frame_cnt_s};
      end
      if (e.at < cyc) begin
        n_fail++;
        $display("FAIL %0s[%0d]: entry for cycle %0d not sampled (now %0d)",
                 e.name, g, e.at, cyc);
      end else if (a.h !== e.h || a.v !== e.v || a.hs !== e.hs || a.vs !== e.vs ||
                   a.hb !== e.hb || a.vb !== e.vb || a.sf !== e.sf || a.fc !== e.fc) begin
        n_fail++;
        $display("FAIL %0s[%0d] cyc %0d: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b sof=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b sof=%b fc=%0d",
                 e.name, g, cyc, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.sf, a.fc,
                 e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.sf, e.fc);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check(0);
      check(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    rst_n_s = 1'b0;
    en_s    = 1'b1;
    for (int g = 0; g < 2; g++) begin
      eh[g] = 0; ev[g] = 0; efc[g] = 0; esof[g] = 1'b0;
    end

    // Full-size raster.
    do_reset(0, 5, "reset");
    rst_n = 1'b1;
    step(0, 1, "first_edge");          // (1,0)
    step(0, 1099, "h_sweep");          // through 1055->0, ends at (44,1)
    en = 1'b0;
    hold(0, 10, "en_hold");
    en = 1'b1;
    step(0, 1, "en_resume");           // (45,1)
    step(0, 455, "to_500");            // (500,1)
    do_reset(0, 1, "mid_reset");       // (0,0), no sof, frame_cnt 0
    rst_n = 1'b1;
    step(0, 1, "post_reset");          // (1,0)

    // Small raster: 160-cycle frames, 2-bit frame counter.
    do_reset(1, 3, "s_reset");
    rst_n_s = 1'b1;
    step(1, 645, "s_frames");          // sof at 160/320/480/640, fc 1,2,3,0
    step(1, 154, "s_to_end");          // (15,9)
    en_s = 1'b0;
    hold(1, 10, "s_en_hold");
    en_s = 1'b1;
    step(1, 1, "s_wrap");              // (0,0) sof=1 fc=1
    en_s = 1'b0;
    hold(1, 1, "s_sof_hold");          // still (0,0), sof forced 0
    en_s = 1'b1;
    step(1, 1, "s_resume");            // (1,0)
    step(1, 100, "s_mid");             // (5,6)
    do_reset(1, 1, "s_mid_rst");
    rst_n_s = 1'b1;
    step(1, 160, "s_post_rst");        // first sof one full frame after reset

    tick();
    tick();
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d entries left unchecked, want 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
